// File: rtl/jts16b_adc_seq_if.sv
// CPU-side bus of the serial ADC sequencer: access qualifiers from the
// cabinet decoder plus the read data and status returned to it.
interface jts16b_adc_seq_if;
    logic       cs;
    logic       wr;
    logic       rd;
    logic [1:0] sel;
    logic [7:0] dout;
    logic       busy;
    logic       ready;

    modport master (
        output cs, wr, rd, sel,
        input  dout, busy, ready
    );

    modport slave (
        input  cs, wr, rd, sel,
        output dout, busy, ready
    );
endinterface

// File: rtl/jts16b_adc_seq.sv
// Serial ADC sequencer for the 68000 cabinet I/O window. A write starts a
// timed conversion of the selected channel; each following read access
// returns one result bit, MSB first, in bit 0 of the read data.
module jts16b_adc_seq #(
    parameter int CONV_CYCLES = 64,
    parameter int BITS        = 8
) (
    input  logic             clk,
    input  logic             rst,
    jts16b_adc_seq_if.slave  bus,
    input  logic [7:0]       ch0,
    input  logic [7:0]       ch1,
    input  logic [7:0]       ch2,
    input  logic [7:0]       ch3
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]      state_q,   state_d;
    logic [BITS-1:0] shreg_q,   shreg_d;
    logic [3:0]      bitcnt_q,  bitcnt_d;
    logic [9:0]      convcnt_q, convcnt_d;
    logic [7:0]      dout_q,    dout_d;
    logic            cs_l_q;
    logic            rd_seen_q, rd_seen_d;
    logic            busy_q;
    logic            ready_q;
    logic            acc_start;
    logic            acc_end;
    logic            wr_start;
    logic            rd_end;
    logic [7:0]      ch_sel;

    // A CPU access is acted on only at its cs edges, so long bus cycles count once.
    assign acc_start = bus.cs & ~cs_l_q;
    assign acc_end   = ~bus.cs & cs_l_q;
    assign wr_start  = acc_start & bus.wr;
    assign rd_end    = acc_end & rd_seen_q;

    // Remember whether the current access was a read, since rd is gone when cs drops.
    always_comb begin
        rd_seen_d = 1'b0;
        if (bus.cs) begin
            rd_seen_d = bus.rd | (rd_seen_q & cs_l_q);
        end
    end

    // Channel mux driven by the CPU address bits.
    always_comb begin
        ch_sel = ch0;
        case (bus.sel)
            2'd1:    ch_sel = ch1;
            2'd2:    ch_sel = ch2;
            2'd3:    ch_sel = ch3;
            default: ch_sel = ch0;
        endcase
    end

    // Sequencer next state; a start write overrides anything else in flight.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        convcnt_d = convcnt_q;
        if (wr_start) begin
            shreg_d   = BITS'(ch_sel);
            convcnt_d = 10'(CONV_CYCLES - 1);
            bitcnt_d  = 4'd0;
            state_d   = ST_CONV;
        end else begin
            case (state_q)
                ST_CONV: begin
                    if (convcnt_q == 10'd0) begin
                        state_d  = ST_READY;
                        bitcnt_d = 4'(BITS);
                    end else begin
                        convcnt_d = convcnt_q - 10'd1;
                    end
                end
                ST_READY: begin
                    if (rd_end) begin
                        shreg_d  = {shreg_q[BITS-2:0], 1'b1};
                        bitcnt_d = bitcnt_q - 4'd1;
                        if (bitcnt_q == 4'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Read data follows the state one cycle later, so it settles after each shift.
    always_comb begin
        dout_d = 8'h01;
        case (state_q)
            ST_CONV:  dout_d = 8'h00;
            ST_READY: dout_d = {7'd0, shreg_q[BITS-1]};
            default:  dout_d = 8'h01;
        endcase
    end

    // State, counters and outputs registered with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '1;
            bitcnt_q  <= 4'd0;
            convcnt_q <= 10'd0;
            dout_q    <= 8'h01;
            cs_l_q    <= 1'b0;
            rd_seen_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            convcnt_q <= convcnt_d;
            dout_q    <= dout_d;
            cs_l_q    <= bus.cs;
            rd_seen_q <= rd_seen_d;
            busy_q    <= (state_d == ST_CONV);
            ready_q   <= (state_d == ST_READY);
        end
    end

    assign bus.dout  = dout_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_jts16b_adc_seq.sv
// Bench for the serial ADC sequencer: CPU-style accesses driven through the
// bus interface, results compared with the channel value sampled at the
// start write, read out MSB first.
module tb_jts16b_adc_seq;
    localparam int CONV = 64;
    localparam int NB   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ch0, ch1, ch2, ch3;
    int         total = 0;
    int         bad   = 0;

    jts16b_adc_seq_if bus();

    jts16b_adc_seq #(.CONV_CYCLES(CONV), .BITS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .ch0 (ch0),
        .ch1 (ch1),
        .ch2 (ch2),
        .ch3 (ch3)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write access, then count how many cycles busy stays high.
    task automatic do_write(input logic [1:0] s, output int n);
        bus.sel = s;
        bus.cs  = 1'b1;
        bus.wr  = 1'b1;
        cyc();
        bus.cs  = 1'b0;
        bus.wr  = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            n++;
            cyc();
        end
    endtask

    // Read access held for len cycles; returns the data seen while held.
    task automatic read_acc(input int len, output logic [7:0] d);
        bus.cs = 1'b1;
        bus.rd = 1'b1;
        repeat (len) cyc();
        d = bus.dout;
        bus.cs = 1'b0;
        bus.rd = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.sel = 2'd0;
        ch0 = 8'h00; ch1 = 8'h00; ch2 = 8'h00; ch3 = 8'h00;
        cyc(); cyc();
        total++; if (bus.dout !== 8'h01) begin bad++; $display("FAIL reset_dout: got %h want 01", bus.dout); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        rst = 1'b0;
        cyc();
        bus.cs = 1'b1; bus.rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (bus.dout !== 8'h01) begin bad++; $display("FAIL idle_read%0d: got %h want 01", i, bus.dout); end
        end
        bus.cs = 1'b0; bus.rd = 1'b0;
        cyc(); cyc();
        total++; if (bus.dout !== 8'h01) begin bad++; $display("FAIL idle_after: got %h want 01", bus.dout); end
    endtask

    task automatic test_conversion();
        logic [7:0] v, d;
        int n;
        v = 8'hA5;
        ch1 = v;
        do_write(2'd1, n);
        total++; if (n != CONV) begin bad++; $display("FAIL conv_busy_len: got %0d want %0d", n, CONV); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL conv_ready: got %b want 1", bus.ready); end
        for (int i = 0; i < NB; i++) begin
            read_acc(2, d);
            total++; if (d !== {7'd0, v[NB-1-i]}) begin bad++; $display("FAIL conv_bit%0d: got %h want %h", i, d, {7'd0, v[NB-1-i]}); end
        end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL conv_ready_end: got %b want 0", bus.ready); end
        cyc();
        total++; if (bus.dout !== 8'h01) begin bad++; $display("FAIL conv_dout_end: got %h want 01", bus.dout); end
    endtask

    task automatic test_busy_read();
        logic [7:0] v, d;
        int n;
        v = 8'h80;
        ch2 = v;
        bus.sel = 2'd2; bus.cs = 1'b1; bus.wr = 1'b1;
        cyc();
        bus.cs = 1'b0; bus.wr = 1'b0;
        repeat (8) cyc();
        bus.cs = 1'b1; bus.rd = 1'b1;
        cyc(); cyc();
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL busy_read_dout: got %h want 00", bus.dout); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_read_busy: got %b want 1", bus.busy); end
        bus.cs = 1'b0; bus.rd = 1'b0;
        cyc();
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin n++; cyc(); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL busy_read_ready: got %b want 1", bus.ready); end
        for (int i = 0; i < NB; i++) begin
            read_acc(2, d);
            total++; if (d !== {7'd0, v[NB-1-i]}) begin bad++; $display("FAIL busy_read_bit%0d: got %h want %h", i, d, {7'd0, v[NB-1-i]}); end
        end
    endtask

    task automatic test_restart();
        logic [7:0] d;
        int n;
        ch0 = 8'hFF;
        ch3 = 8'h00;
        do_write(2'd0, n);
        for (int i = 0; i < 3; i++) begin
            read_acc(2, d);
            total++; if (d !== 8'h01) begin bad++; $display("FAIL restart_pre%0d: got %h want 01", i, d); end
        end
        do_write(2'd3, n);
        total++; if (n != CONV) begin bad++; $display("FAIL restart_busy_len: got %0d want %0d", n, CONV); end
        for (int i = 0; i < NB; i++) begin
            read_acc(2, d);
            total++; if (d !== 8'h00) begin bad++; $display("FAIL restart_bit%0d: got %h want 00", i, d); end
        end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL restart_ready_end: got %b want 0", bus.ready); end
    endtask

    task automatic test_long_access();
        logic [7:0] v, d;
        int n;
        v = 8'h0F;
        ch2 = v;
        do_write(2'd2, n);
        for (int i = 0; i < NB; i++) begin
            read_acc(20, d);
            total++; if (d !== {7'd0, v[NB-1-i]}) begin bad++; $display("FAIL long_bit%0d: got %h want %h", i, d, {7'd0, v[NB-1-i]}); end
        end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL long_ready_end: got %b want 0", bus.ready); end
    endtask

    task automatic test_collision();
        logic [7:0] v, d;
        int n;
        v = 8'($urandom);
        ch1 = v;
        do_write(2'd1, n);
        for (int i = 0; i < NB - 1; i++) begin
            read_acc(2, d);
            total++; if (d !== {7'd0, v[NB-1-i]}) begin bad++; $display("FAIL coll_bit%0d: got %h want %h", i, d, {7'd0, v[NB-1-i]}); end
        end
        // Last read ends, and the very next cycle a new write starts.
        bus.cs = 1'b1; bus.rd = 1'b1;
        cyc(); cyc();
        total++; if (bus.dout !== {7'd0, v[0]}) begin bad++; $display("FAIL coll_last: got %h want %h", bus.dout, {7'd0, v[0]}); end
        bus.cs = 1'b0; bus.rd = 1'b0;
        cyc();
        bus.sel = 2'd0; bus.cs = 1'b1; bus.wr = 1'b1;
        cyc();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL coll_busy: got %b want 1", bus.busy); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL coll_ready: got %b want 0", bus.ready); end
        bus.cs = 1'b0; bus.wr = 1'b0;
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midconv_rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.dout !== 8'h01) begin bad++; $display("FAIL midconv_rst_dout: got %h want 01", bus.dout); end
        rst = 1'b0;
        repeat (3) cyc();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midconv_rst_stay: got %b want 0", bus.busy); end
    endtask

    task automatic test_random();
        logic [7:0] chv [4];
        logic [7:0] v, d;
        logic [1:0] s;
        int n;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 4; c++) chv[c] = 8'($urandom);
            ch0 = chv[0]; ch1 = chv[1]; ch2 = chv[2]; ch3 = chv[3];
            s = 2'($urandom_range(0, 3));
            v = chv[s];
            do_write(s, n);
            total++; if (n != CONV) begin bad++; $display("FAIL rnd%0d_busy_len: got %0d want %0d", k, n, CONV); end
            // Channel inputs moving after the start write must not matter.
            ch0 = 8'($urandom); ch1 = 8'($urandom); ch2 = 8'($urandom); ch3 = 8'($urandom);
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.cs = 1'b1;
                    repeat ($urandom_range(1, 4)) cyc();
                    bus.cs = 1'b0;
                    cyc();
                end
                read_acc($urandom_range(2, 6), d);
                total++; if (d !== {7'd0, v[NB-1-i]}) begin bad++; $display("FAIL rnd%0d_bit%0d: got %h want %h", k, i, d, {7'd0, v[NB-1-i]}); end
            end
            total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rnd%0d_ready_end: got %b want 0", k, bus.ready); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_busy_read();
        test_restart();
        test_long_access();
        test_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
